// File: rtl/npu_act_wr_arbiter_pkg.sv
// Shared types and constants for the activation-memory write arbiter.
// The optional statistics block is enabled with the NPU_ACT_WR_ARB_STATS_EN macro.
// The activation data width defaults to the 16-bit NPU activation width.
package npu_act_wr_arbiter_pkg;

    // Arbiter control states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2
    } arb_state_e;

    // Default geometry of the NPU layer unit writeback path
    localparam int DEF_NUM_REQ = 32;
    localparam int DEF_ADDR_W  = 12;
    localparam int DEF_DATA_W  = 16;

    // Width of a lane index / round-robin pointer, never below one bit
    function automatic int ptrWidth(input int numLanes);
        return (numLanes > 1) ? $clog2(numLanes) : 1;
    endfunction

    localparam int RR_PTR_W = ptrWidth(DEF_NUM_REQ);

`ifdef NPU_ACT_WR_ARB_STATS_EN
    // Statistics counter widths
    localparam int STATS_CNT_W = 16;
    localparam int STATS_WAIT_W = 6;
`endif

endpackage

// File: rtl/npu_act_wr_arbiter_if.sv
// Bus bundle between the MAC-lane writeback requesters / control unit and the
// activation write arbiter, including the registered memory write port.
// Signal prefixes are written from the arbiter's point of view.
interface npu_act_wr_arbiter_if
    import npu_act_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
);
    logic                        i_enable;
    logic                        i_flushReqP;
    logic                        o_flushDoneP;
    logic [NUM_REQ-1:0]          i_req;
    logic [NUM_REQ*ADDR_W-1:0]   i_reqAddr;
    logic [NUM_REQ*DATA_W-1:0]   i_reqData;
    logic [NUM_REQ-1:0]          o_ackP;
    logic                        o_memWrEn;
    logic [ADDR_W-1:0]           o_memWrAddr;
    logic [DATA_W-1:0]           o_memWrData;
    logic                        o_busy;

    // Requesters and control unit drive the request side
    modport master (
        output i_enable, i_flushReqP, i_req, i_reqAddr, i_reqData,
        input  o_flushDoneP, o_ackP, o_memWrEn, o_memWrAddr, o_memWrData, o_busy
    );

    // The arbiter consumes requests and drives acks and the memory port
    modport slave (
        input  i_enable, i_flushReqP, i_req, i_reqAddr, i_reqData,
        output o_flushDoneP, o_ackP, o_memWrEn, o_memWrAddr, o_memWrData, o_busy
    );
endinterface

// File: rtl/npu_act_wr_arbiter_rr_pick.sv
// Combinational rotate-priority selector: starting at the pointer lane and
// walking upwards with wrap-around, returns the first requesting lane.
// Lane count must be a power of two so pointer arithmetic wraps naturally.
module npu_act_wr_arbiter_rr_pick
    import npu_act_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int PTR_W   = RR_PTR_W
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic [PTR_W-1:0]   o_idx,
    output logic               o_valid
);
    logic               w_found;
    logic [PTR_W-1:0]   w_idx;
    logic [PTR_W-1:0]   w_cand;

    // Scan lanes in rotated order and latch onto the first request seen
    always_comb begin
        w_found = 1'b0;
        w_idx   = i_ptr;
        w_cand  = i_ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = i_ptr + PTR_W'(i);
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
    end

    assign o_valid  = w_found;
    assign o_idx    = w_idx;
    assign o_onehot = w_found ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << w_idx) : '0;

endmodule

// File: rtl/npu_act_wr_arbiter.sv
// Round-robin arbiter for the single activation-memory write port shared by the
// MAC-lane writeback requesters. One grant per cycle, same-cycle ack pulse,
// registered memory write one cycle later, plus a flush/drain handshake.
// Optional write/wait statistics are enabled with NPU_ACT_WR_ARB_STATS_EN.
module npu_act_wr_arbiter
    import npu_act_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic                 clk,
    input  logic                 rst,
    npu_act_wr_arbiter_if.slave  bus
`ifdef NPU_ACT_WR_ARB_STATS_EN
    ,
    output logic [STATS_CNT_W-1:0]  o_wrCount,
    output logic [STATS_WAIT_W-1:0] o_maxWait
`endif
);
    localparam int PTR_W = ptrWidth(NUM_REQ);

    arb_state_e         r_state;
    logic [PTR_W-1:0]   r_rrPtr;
    logic               r_memWrEn;
    logic [ADDR_W-1:0]  r_memWrAddr;
    logic [DATA_W-1:0]  r_memWrData;
    logic               r_flushDone;

    logic [NUM_REQ-1:0] w_pickOneHot;
    logic [PTR_W-1:0]   w_pickIdx;
    logic               w_pickValid;
    logic               w_grant;
    logic [ADDR_W-1:0]  w_selAddr;
    logic [DATA_W-1:0]  w_selData;

    npu_act_wr_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .i_req    (bus.i_req),
        .i_ptr    (r_rrPtr),
        .o_onehot (w_pickOneHot),
        .o_idx    (w_pickIdx),
        .o_valid  (w_pickValid)
    );

    // A flush pulse in the same cycle always beats a pending grant
    assign w_grant   = (r_state == ACTIVE) && bus.i_enable && !bus.i_flushReqP && w_pickValid;
    assign w_selAddr = bus.i_reqAddr[int'(w_pickIdx)*ADDR_W +: ADDR_W];
    assign w_selData = bus.i_reqData[int'(w_pickIdx)*DATA_W +: DATA_W];

    assign bus.o_ackP        = w_grant ? w_pickOneHot : '0;
    assign bus.o_memWrEn     = r_memWrEn;
    assign bus.o_memWrAddr   = r_memWrAddr;
    assign bus.o_memWrData   = r_memWrData;
    assign bus.o_flushDoneP  = r_flushDone;
    assign bus.o_busy        = (r_state != IDLE) || r_memWrEn;

    // Control FSM; the drain-complete pulse is registered alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_flushDone <= 1'b0;
        end else begin
            r_flushDone <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.i_flushReqP)
                        r_state <= FLUSH;
                    else if (bus.i_enable)
                        r_state <= ACTIVE;
                end
                ACTIVE: begin
                    if (bus.i_flushReqP)
                        r_state <= FLUSH;
                    else if (!bus.i_enable)
                        r_state <= IDLE;
                end
                FLUSH: begin
                    if (!r_memWrEn) begin
                        r_state     <= IDLE;
                        r_flushDone <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Round-robin pointer moves just past the winner; untouched when nothing is granted
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_rrPtr <= '0;
        else if (w_grant)
            r_rrPtr <= w_pickIdx + PTR_W'(1);
    end

    // Output write register; address/data hold their last value between writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_memWrEn   <= 1'b0;
            r_memWrAddr <= '0;
            r_memWrData <= '0;
        end else begin
            r_memWrEn <= w_grant;
            if (w_grant) begin
                r_memWrAddr <= w_selAddr;
                r_memWrData <= w_selData;
            end
        end
    end

`ifdef NPU_ACT_WR_ARB_STATS_EN
    logic [STATS_CNT_W-1:0]  r_wrCount;
    logic [STATS_WAIT_W-1:0] r_maxWait;
    logic [STATS_WAIT_W-1:0] r_laneWait [NUM_REQ];
    logic                    w_enterActive;

    assign w_enterActive = (r_state == IDLE) && bus.i_enable && !bus.i_flushReqP;
    assign o_wrCount     = r_wrCount;
    assign o_maxWait     = r_maxWait;

    // Saturating write count and per-lane wait tracking, restarted at each layer start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrCount <= '0;
            r_maxWait <= '0;
            for (int k = 0; k < NUM_REQ; k++)
                r_laneWait[k] <= '0;
        end else if (w_enterActive) begin
            r_wrCount <= '0;
            r_maxWait <= '0;
            for (int k = 0; k < NUM_REQ; k++)
                r_laneWait[k] <= '0;
        end else begin
            if (w_grant && (r_wrCount != '1))
                r_wrCount <= r_wrCount + 1'b1;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (bus.o_ackP[k]) begin
                    if (r_laneWait[k] > r_maxWait)
                        r_maxWait <= r_laneWait[k];
                    r_laneWait[k] <= '0;
                end else if (bus.i_req[k] && (r_laneWait[k] != '1)) begin
                    r_laneWait[k] <= r_laneWait[k] + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_npu_act_wr_arbiter.sv
// Directed, table-driven bench for the activation write arbiter, with
// hand-written sequences for the full rotation, mid-operation reset and stats.
module tb_npu_act_wr_arbiter;
    import npu_act_wr_arbiter_pkg::*;

    localparam int NR = 32;
    localparam int AW = 12;
    localparam int DW = DEF_DATA_W;
    localparam int NVEC = 26;

    logic clk;
    logic rst;
    int   checkCount;
    int   passCount;

    npu_act_wr_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef NPU_ACT_WR_ARB_STATS_EN
    logic [15:0] wrCount;
    logic [5:0]  maxWait;
`endif

    npu_act_wr_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef NPU_ACT_WR_ARB_STATS_EN
        ,
        .o_wrCount (wrCount),
        .o_maxWait (maxWait)
`endif
    );

    typedef struct {
        logic          en;
        logic          fl;
        logic [NR-1:0] req;
        logic [NR-1:0] ack;
        logic          wrEn;
        int            wrLane;
        logic          done;
        logic          busy;
    } vec_t;

    vec_t vecs [NVEC];

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fixed per-lane write payloads; lane 5 carries the single-lane pattern
    function automatic logic [AW-1:0] laneAddr(input int k);
        return (k == 5) ? AW'(12'h123) : AW'(12'h100 + k);
    endfunction

    function automatic logic [DW-1:0] laneData(input int k);
        return (k == 5) ? DW'(16'h00AB) : DW'(16'hA000 + k);
    endfunction

    function automatic logic [NR-1:0] laneBit(input int k);
        logic [NR-1:0] one;
        one = 1;
        return one << k;
    endfunction

    function automatic vec_t mkVec(input logic en, input logic fl, input logic [NR-1:0] req,
                                   input logic [NR-1:0] ack, input logic wrEn, input int wrLane,
                                   input logic done, input logic busy);
        vec_t v;
        v.en = en; v.fl = fl; v.req = req; v.ack = ack;
        v.wrEn = wrEn; v.wrLane = wrLane; v.done = done; v.busy = busy;
        return v;
    endfunction

    task automatic applyStimulus(input logic en, input logic fl, input logic [NR-1:0] req);
        bus.i_enable    = en;
        bus.i_flushReqP = fl;
        bus.i_req       = req;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected)
            passCount++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Watchdog so a stuck run still reports and ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int writes;
        checkCount = 0;
        passCount  = 0;
        for (int k = 0; k < NR; k++) begin
            bus.i_reqAddr[k*AW +: AW] = laneAddr(k);
            bus.i_reqData[k*DW +: DW] = laneData(k);
        end

        //            en  fl  req                      ack          wrEn lane done busy
        vecs[0]  = mkVec(1, 0, '1,                     '0,          0, 0,  0, 0);
        vecs[1]  = mkVec(1, 0, '1,                     laneBit(0),  0, 0,  0, 1);
        vecs[2]  = mkVec(0, 0, '0,                     '0,          1, 0,  0, 1);
        vecs[3]  = mkVec(0, 0, '0,                     '0,          0, 0,  0, 0);
        vecs[4]  = mkVec(1, 0, laneBit(5),             '0,          0, 0,  0, 0);
        vecs[5]  = mkVec(1, 0, laneBit(5),             laneBit(5),  0, 0,  0, 1);
        vecs[6]  = mkVec(1, 0, laneBit(4)|laneBit(7),  laneBit(7),  1, 5,  0, 1);
        vecs[7]  = mkVec(1, 0, laneBit(4),             laneBit(4),  1, 7,  0, 1);
        vecs[8]  = mkVec(1, 0, '0,                     '0,          1, 4,  0, 1);
        vecs[9]  = mkVec(1, 0, '0,                     '0,          0, 0,  0, 1);
        vecs[10] = mkVec(1, 1, laneBit(3),             '0,          0, 0,  0, 1);
        vecs[11] = mkVec(1, 0, laneBit(3),             '0,          0, 0,  0, 1);
        vecs[12] = mkVec(0, 0, laneBit(3),             '0,          0, 0,  1, 0);
        vecs[13] = mkVec(0, 0, '0,                     '0,          0, 0,  0, 0);
        vecs[14] = mkVec(1, 0, '0,                     '0,          0, 0,  0, 0);
        vecs[15] = mkVec(1, 0, laneBit(9),             laneBit(9),  0, 0,  0, 1);
        vecs[16] = mkVec(1, 1, laneBit(9),             '0,          1, 9,  0, 1);
        vecs[17] = mkVec(0, 1, '0,                     '0,          0, 0,  0, 1);
        vecs[18] = mkVec(0, 0, '0,                     '0,          0, 0,  1, 0);
        vecs[19] = mkVec(0, 0, '0,                     '0,          0, 0,  0, 0);
        vecs[20] = mkVec(1, 0, '0,                     '0,          0, 0,  0, 0);
        vecs[21] = mkVec(1, 0, laneBit(29),            laneBit(29), 0, 0,  0, 1);
        vecs[22] = mkVec(1, 0, laneBit(1)|laneBit(29), laneBit(1),  1, 29, 0, 1);
        vecs[23] = mkVec(1, 0, laneBit(29),            laneBit(29), 1, 1,  0, 1);
        vecs[24] = mkVec(0, 0, '0,                     '0,          1, 29, 0, 1);
        vecs[25] = mkVec(0, 0, '0,                     '0,          0, 0,  0, 0);

        // Reset held with every lane requesting
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, '1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset ack", 64'(bus.o_ackP), 64'(0));
        checkOutput("reset wrEn", 64'(bus.o_memWrEn), 64'(0));
        checkOutput("reset busy", 64'(bus.o_busy), 64'(0));
        checkOutput("reset flushDone", 64'(bus.o_flushDoneP), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].en, vecs[i].fl, vecs[i].req);
            @(negedge clk);
            checkOutput($sformatf("vec%0d ack", i), 64'(bus.o_ackP), 64'(vecs[i].ack));
            checkOutput($sformatf("vec%0d wrEn", i), 64'(bus.o_memWrEn), 64'(vecs[i].wrEn));
            checkOutput($sformatf("vec%0d flushDone", i), 64'(bus.o_flushDoneP), 64'(vecs[i].done));
            checkOutput($sformatf("vec%0d busy", i), 64'(bus.o_busy), 64'(vecs[i].busy));
            if (vecs[i].wrEn) begin
                checkOutput($sformatf("vec%0d addr", i), 64'(bus.o_memWrAddr), 64'(laneAddr(vecs[i].wrLane)));
                checkOutput($sformatf("vec%0d data", i), 64'(bus.o_memWrData), 64'(laneData(vecs[i].wrLane)));
            end
            @(posedge clk);
            #1;
        end

        // Address/data hold the last write while idle
        applyStimulus(1'b0, 1'b0, '0);
        @(negedge clk);
        checkOutput("hold addr", 64'(bus.o_memWrAddr), 64'(laneAddr(29)));
        checkOutput("hold data", 64'(bus.o_memWrData), 64'(laneData(29)));
        @(posedge clk);
        #1;

        // Full rotation: park the pointer at 0 via lane 31, then all lanes request
        applyStimulus(1'b1, 1'b0, '0);
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, laneBit(31));
        @(negedge clk);
        checkOutput("rot lane31 ack", 64'(bus.o_ackP), 64'(laneBit(31)));
        @(posedge clk);
        #1;
        writes = 0;
        for (int j = 0; j <= NR; j++) begin
            applyStimulus(1'b1, 1'b0, '1);
            @(negedge clk);
            checkOutput($sformatf("rot%0d ack", j), 64'(bus.o_ackP), 64'(laneBit(j % NR)));
            checkOutput($sformatf("rot%0d addr", j), 64'(bus.o_memWrAddr),
                        64'(laneAddr((j == 0) ? 31 : j - 1)));
            if (j >= 1 && bus.o_memWrEn)
                writes++;
            @(posedge clk);
            #1;
        end
        checkOutput("rot write count", 64'(writes), 64'(NR));
        applyStimulus(1'b0, 1'b0, '0);
        @(negedge clk);
        checkOutput("rot last wrEn", 64'(bus.o_memWrEn), 64'(1));
        checkOutput("rot last addr", 64'(bus.o_memWrAddr), 64'(laneAddr(0)));
        @(posedge clk);
        #1;

        // Reset between grant and write discards the write and rewinds the pointer
        applyStimulus(1'b1, 1'b0, '0);
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, laneBit(6));
        @(negedge clk);
        checkOutput("midrst ack", 64'(bus.o_ackP), 64'(laneBit(6)));
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst wrEn", 64'(bus.o_memWrEn), 64'(0));
        checkOutput("midrst busy", 64'(bus.o_busy), 64'(0));
        checkOutput("midrst addr", 64'(bus.o_memWrAddr), 64'(0));
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, laneBit(2) | laneBit(31));
        @(negedge clk);
        checkOutput("postrst idle ack", 64'(bus.o_ackP), 64'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("postrst ptr0 ack", 64'(bus.o_ackP), 64'(laneBit(2)));
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, '0);
        @(posedge clk);
        #1;

`ifdef NPU_ACT_WR_ARB_STATS_EN
        // Two lanes each issue ten writes back to back
        begin
            int left0;
            int left1;
            int cycles;
            left0 = 10;
            left1 = 10;
            cycles = 0;
            applyStimulus(1'b1, 1'b0, '0);
            @(posedge clk);
            #1;
            while ((left0 > 0 || left1 > 0) && cycles < 40) begin
                applyStimulus(1'b1, 1'b0, (left0 > 0 ? laneBit(0) : '0) | (left1 > 0 ? laneBit(1) : '0));
                @(negedge clk);
                if (bus.o_ackP[0]) left0--;
                if (bus.o_ackP[1]) left1--;
                @(posedge clk);
                #1;
                cycles++;
            end
            checkOutput("stats drained", 64'(left0 + left1), 64'(0));
            applyStimulus(1'b0, 1'b0, '0);
            @(negedge clk);
            checkOutput("stats wrCount", 64'(wrCount), 64'(20));
            checkOutput("stats maxWait", 64'(maxWait), 64'(1));
            @(posedge clk);
            #1;
        end
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
